// File: rtl/exp3_fluxo_dados_pkg.sv
// Shared constants for the experiment-3 datapath: default widths and the
// fixed ROM contents that the datapath compares the registered switches against.
package exp3_pkg;

    localparam int N_DEF = 4;
    localparam int M_DEF = 4;

    typedef logic [N_DEF-1:0] rom_t [2**M_DEF];

    localparam rom_t ROM_CONTENT = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100,
        4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

endpackage

// File: rtl/exp3_fluxo_dados_contador_m.sv
// M-bit up counter with synchronous clear, count enable, asynchronous reset
// and a combinational ripple-carry-out flag at terminal count.
module contador_m #(
    parameter int M = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [M-1:0] q,
    output logic         rco
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            q <= q + 1'b1;
        end
    end

    assign rco = (q == {M{1'b1}});

endmodule

// File: rtl/exp3_fluxo_dados.sv
// Datapath for the experiment-3 control unit: address counter, fixed ROM,
// switch register and equality comparator, plus debug taps for the displays.
import exp3_pkg::*;

module exp3_fluxo_dados #(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zeraC,
    input  logic         contaC,
    input  logic         zeraR,
    input  logic         registraR,
    input  logic [N-1:0] chaves,
    output logic         fimC,
    output logic         chavesIgualMemoria,
    output logic [M-1:0] db_contagem,
    output logic [N-1:0] db_memoria,
    output logic [N-1:0] db_chaves
);

    logic [M-1:0] contagem;
    logic [N-1:0] registro;
    logic [N-1:0] memoria;

    contador_m #(.M(M)) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zeraC),
        .conta (contaC),
        .q     (contagem),
        .rco   (fimC)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            registro <= '0;
        end else if (zeraR) begin
            registro <= '0;
        end else if (registraR) begin
            registro <= chaves;
        end
    end

    // Asynchronous ROM read straight off the counter value.
    assign memoria            = ROM_CONTENT[contagem];
    assign chavesIgualMemoria = (registro == memoria);

    assign db_contagem = contagem;
    assign db_memoria  = memoria;
    assign db_chaves   = registro;

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Self-checking bench for exp3_fluxo_dados: directed scenarios plus random
// control sequences compared against an arithmetic model of count and register.
import exp3_pkg::*;

module tb_exp3_fluxo_dados;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       zeraC = 1'b0;
    logic       contaC = 1'b0;
    logic       zeraR = 1'b0;
    logic       registraR = 1'b0;
    logic [3:0] chaves = 4'd0;
    logic       fimC;
    logic       chavesIgualMemoria;
    logic [3:0] db_contagem;
    logic [3:0] db_memoria;
    logic [3:0] db_chaves;

    int total = 0;
    int fails = 0;
    int model_count = 0;
    int model_reg = 0;

    exp3_fluxo_dados dut (
        .clock              (clock),
        .reset              (reset),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .chaves             (chaves),
        .fimC               (fimC),
        .chavesIgualMemoria (chavesIgualMemoria),
        .db_contagem        (db_contagem),
        .db_memoria         (db_memoria),
        .db_chaves          (db_chaves)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int rom_word;
        rom_word = int'(ROM_CONTENT[model_count]);
        chk({tag, ".contagem"}, int'(db_contagem), model_count);
        chk({tag, ".chaves"}, int'(db_chaves), model_reg);
        chk({tag, ".memoria"}, int'(db_memoria), rom_word);
        chk({tag, ".fimC"}, int'(fimC), (model_count == 15) ? 1 : 0);
        chk({tag, ".igual"}, int'(chavesIgualMemoria), (model_reg == rom_word) ? 1 : 0);
    endtask

    // Drive one set of controls across a rising edge, advance the model, then check.
    task automatic step(input logic zc, input logic cc, input logic zr,
                        input logic rr, input logic [3:0] ch, input string tag);
        zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; chaves = ch;
        @(posedge clock);
        if (zc)      model_count = 0;
        else if (cc) model_count = (model_count + 1) % 16;
        if (zr)      model_reg = 0;
        else if (rr) model_reg = int'(ch);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_count = 0;
        model_reg = 0;
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        // Reset held with no clock edge yet.
        #1;
        check_all("reset");
        chk("reset.memoria_const", int'(db_memoria), 1);
        #3 reset = 1'b0;

        // Count 0..15 and wrap back to 0.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 4'd0, "wrap");
        chk("wrap.back_to_zero", int'(db_contagem), 0);

        // Register and compare at address 3, then one more increment.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'd0, "to3");
        step(0, 0, 0, 1, 4'b1000, "reg3");
        chk("reg3.igual_const", int'(chavesIgualMemoria), 1);
        step(0, 1, 0, 0, 4'd0, "inc4");
        chk("inc4.memoria_const", int'(db_memoria), 4);
        chk("inc4.igual_const", int'(chavesIgualMemoria), 0);

        // Priorities: clear beats enable on both the counter and the register.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'd0, "to7");
        step(1, 1, 0, 0, 4'd0, "prio_cnt");
        chk("prio_cnt.zero", int'(db_contagem), 0);
        step(0, 0, 0, 1, 4'b0110, "load");
        step(0, 0, 1, 1, 4'b1111, "prio_reg");
        chk("prio_reg.zero", int'(db_chaves), 0);
        step(1, 0, 1, 0, 4'd0, "clr_both");

        // Control-unit style walk: register, compare, advance.
        for (int a = 0; a < 16; a++) begin
            step(0, 0, 0, 1, ROM_CONTENT[a], "walk_reg");
            chk("walk.igual", int'(chavesIgualMemoria), 1);
            chk("walk.fimC", int'(fimC), (a == 15) ? 1 : 0);
            step(0, 1, 0, 0, 4'd0, "walk_next");
        end

        // Simultaneous advance and capture.
        step(0, 1, 0, 1, ROM_CONTENT[1], "both");
        chk("both.igual", int'(chavesIgualMemoria), 1);

        // Mid-operation reset at count 9, register 0010.
        step(1, 0, 0, 1, 4'b0010, "pre9");
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 4'd0, "to9");
        chk("pre_reset.count", int'(db_contagem), 9);
        async_reset("midreset");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'd0, "resume");
        chk("resume.count", int'(db_contagem), 3);

        // Random control sequences, including occasional asynchronous resets.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] ch;
            ch = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ch = ROM_CONTENT[$urandom_range(0, 15)];
            step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 2) == 0),
                 ch, "rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/exp3_fluxo_dados.md
Name: exp3_fluxo_dados

Overview:
- Datapath companion to the experiment-3 control unit. Sits directly downstream of the control FSM: consumes zeraC, contaC, zeraR and registraR, and returns fimC.
- Holds a mod-16 address counter, a 16x4 ROM addressed by that counter, and a 4-bit register that captures the switches.
- An equality comparator checks the register against the ROM word.
- Exposes depuration outputs for the board displays.

Parameters:
- N, 4, data width of ROM words, switch input and register.
- M, 4, counter/address width; the ROM depth is 2**M.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears counter and register immediately.
- zeraC  input  1  synchronous clear of the counter.
- contaC  input  1  counter increment enable.
- zeraR  input  1  synchronous clear of the register.
- registraR  input  1  register load enable (captures chaves).
- chaves  input  N  switch value to be registered.
- fimC  output  1  high while the counter equals 2**M-1 (terminal count).
- chavesIgualMemoria  output  1  high when the register equals the ROM word at the current address.
- db_contagem  output  M  current counter value.
- db_memoria  output  N  ROM word at the current address.
- db_chaves  output  N  current register contents.

Behaviour:
- Reset (asynchronous, active-high):
  - Counter and register go to 0 at once, independent of clock.
  - Outputs after reset: db_contagem=0, db_chaves=0, db_memoria=ROM[0]=4'b0001, fimC=0, chavesIgualMemoria=0.
  - Reset asserted mid-sequence aborts everything; there is no other retained state.
- Counter, on the rising edge:
  - zeraC=1: count<=0. zeraC has priority over contaC.
  - else contaC=1: count<=count+1, modulo 2**M. Wrap-around: 15 with contaC gives 0 on the next edge.
  - else: hold.
- fimC is combinational from the count: fimC=(count==2**M-1). Zero-latency relative to the counter value.
- Register, on the rising edge:
  - zeraR=1: reg<=0. zeraR has priority over registraR.
  - else registraR=1: reg<=chaves.
  - else: hold.
  - One-cycle latency: db_chaves shows the captured value in the cycle after the enable.
- ROM:
  - Asynchronous read, data = ROM[count].
  - Fixed contents, address 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- Comparator: chavesIgualMemoria = (reg == ROM[count]), purely combinational. It reflects a new counter value or register value in the same cycle that value appears.
- Simultaneous events:
  - zeraC together with zeraR in the same cycle clears both.
  - contaC together with registraR in the same cycle: the register captures chaves and the counter advances on the same edge. The next-cycle comparison uses the new address against the new register value.
- No X propagation: every output is defined from reset onward. Unused enable combinations hold state.

Decomposition:
- Shared package (exp3_pkg): N and M defaults and the ROM contents constant (16xN array). The test bench reuses the same table for expected values.
- One natural sub-module: contador_m (M-bit counter with synchronous clear, enable, asynchronous reset and rco output). fimC is driven from its rco.
- The register, ROM and comparator stay inline.

Test Plan:
- Reset: pulse reset with no clock edge -> db_contagem=0, db_chaves=0, db_memoria=0001, fimC=0, chavesIgualMemoria=0.
- Count and wrap: hold contaC=1 for 16 edges -> db_contagem runs 0..15 then 0. fimC=1 only while at 15. db_memoria tracks the ROM table each cycle.
- Register and compare: count=3, chaves=1000, pulse registraR -> next cycle db_chaves=1000, chavesIgualMemoria=1. Then one contaC edge -> count=4, ROM=0100, chavesIgualMemoria=0.
- Priorities: zeraC=contaC=1 at count=7 -> count=0. zeraR=registraR=1 with chaves=1111 -> db_chaves=0.
- Full-sequence walk: drive the control-unit pattern (registra, compare, proximo) with chaves set to each ROM word -> chavesIgualMemoria=1 at all 16 addresses, fimC=1 at address 15.
- Reset mid-operation: count=9, reg=0010, assert reset between clock edges -> both clear immediately. Normal counting resumes from 0 after release.
